// File: rtl/sevenseg_result_display.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sevenseg_result_display: 8-bit result -> 4-digit 7-seg (hex/dec/signed)  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module sevenseg_result_display #(
  parameter int REFRESH_DIV = 100000,
  parameter int CNT_W       = 17
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] value,
  input  logic [1:0] mode,
  input  logic       load,
  output logic       busy,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [4:0] DIG_DASH  = 5'd16;
  localparam logic [4:0] DIG_BLANK = 5'd31;
  localparam logic [1:0] MODE_HEX  = 2'b00;
  localparam logic [1:0] MODE_BLK  = 2'b11;
  localparam logic [1:0] MODE_SDEC = 2'b10;

  state_t          state_q, state_d;
  logic [2:0]      iter_q, iter_d;
  logic [19:0]     sh_q, sh_d;       // {hundreds, tens, units, binary}
  logic [1:0]      mode_q, mode_d;
  logic            neg_q, neg_d;
  logic            pend_vld_q, pend_vld_d;
  logic [7:0]      pend_val_q, pend_val_d;
  logic [1:0]      pend_mode_q, pend_mode_d;
  logic [3:0][4:0] digit_q, digit_d;
  logic            busy_q, busy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]      idx_q, idx_d;
  logic [3:0]      an_q, an_d;
  logic [6:0]      seg_q, seg_d;

  logic            cap;
  logic [7:0]      cap_val;
  logic [1:0]      cap_mode;
  logic            cap_neg;
  logic [7:0]      cap_mag;
  logic [3:0]      hund, tens, units;

  function automatic logic [19:0] dabble(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int i = 0; i < 3; i++) begin
      if (r[8+4*i +: 4] >= 4'd5) r[8+4*i +: 4] = r[8+4*i +: 4] + 4'd3;
    end
    return {r[18:0], 1'b0};
  endfunction

  function automatic logic [6:0] decode(input logic [4:0] d);
    logic [6:0] s;
    case (d)
      5'd0:    s = 7'b1000000;
      5'd1:    s = 7'b1111001;
      5'd2:    s = 7'b0100100;
      5'd3:    s = 7'b0110000;
      5'd4:    s = 7'b0011001;
      5'd5:    s = 7'b0010010;
      5'd6:    s = 7'b0000010;
      5'd7:    s = 7'b1111000;
      5'd8:    s = 7'b0000000;
      5'd9:    s = 7'b0010000;
      5'd10:   s = 7'b0001000;
      5'd11:   s = 7'b0000011;
      5'd12:   s = 7'b1000110;
      5'd13:   s = 7'b0100001;
      5'd14:   s = 7'b0000110;
      5'd15:   s = 7'b0001110;
      DIG_DASH: s = 7'b0111111;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  assign hund  = sh_q[19:16];
  assign tens  = sh_q[15:12];
  assign units = sh_q[11:8];

  always_comb begin
    state_d     = state_q;
    iter_d      = iter_q;
    sh_d        = sh_q;
    mode_d      = mode_q;
    neg_d       = neg_q;
    pend_vld_d  = pend_vld_q;
    pend_val_d  = pend_val_q;
    pend_mode_d = pend_mode_q;
    digit_d     = digit_q;
    cap         = 1'b0;
    cap_val     = value;
    cap_mode    = mode;

    case (state_q)
      IDLE: begin
        cap = load;
      end
      CONV: begin
        sh_d   = dabble(sh_q);
        iter_d = iter_q + 3'd1;
        if (iter_q == 3'd7) state_d = COMMIT;
        if (load) begin
          pend_vld_d  = 1'b1;
          pend_val_d  = value;
          pend_mode_d = mode;
        end
      end
      COMMIT: begin
        case (mode_q)
          MODE_HEX: digit_d = {DIG_BLANK, DIG_BLANK, {1'b0, sh_q[7:4]}, {1'b0, sh_q[3:0]}};
          MODE_BLK: digit_d = {4{DIG_BLANK}};
          default: begin
            digit_d[3] = neg_q ? DIG_DASH : DIG_BLANK;
            digit_d[2] = (hund != 4'd0) ? {1'b0, hund} : DIG_BLANK;
            digit_d[1] = (hund != 4'd0 || tens != 4'd0) ? {1'b0, tens} : DIG_BLANK;
            digit_d[0] = {1'b0, units};
          end
        endcase
        // A load on the commit edge overrides whatever is pending
        if (load) begin
          cap = 1'b1;
        end else if (pend_vld_q) begin
          cap      = 1'b1;
          cap_val  = pend_val_q;
          cap_mode = pend_mode_q;
        end else begin
          state_d = IDLE;
        end
        pend_vld_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase

    cap_neg = (cap_mode == MODE_SDEC) && cap_val[7];
    cap_mag = cap_neg ? (8'd0 - cap_val) : cap_val;
    if (cap) begin
      mode_d  = cap_mode;
      neg_d   = cap_neg;
      sh_d    = {12'd0, cap_mag};
      iter_d  = 3'd0;
      state_d = (cap_mode == MODE_HEX || cap_mode == MODE_BLK) ? COMMIT : CONV;
    end

    busy_d = (state_d != IDLE);

    an_d  = ~(4'b0001 << idx_q);
    seg_d = decode(digit_q[idx_q]);
    if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      cnt_d = '0;
      idx_d = idx_q + 2'd1;
    end else begin
      cnt_d = cnt_q + 1'b1;
      idx_d = idx_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      iter_q      <= 3'd0;
      sh_q        <= 20'd0;
      mode_q      <= 2'b00;
      neg_q       <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_val_q  <= 8'd0;
      pend_mode_q <= 2'b00;
      digit_q     <= {4{DIG_BLANK}};
      busy_q      <= 1'b0;
      cnt_q       <= '0;
      idx_q       <= 2'd0;
      an_q        <= 4'hF;
      seg_q       <= 7'h7F;
    end else begin
      state_q     <= state_d;
      iter_q      <= iter_d;
      sh_q        <= sh_d;
      mode_q      <= mode_d;
      neg_q       <= neg_d;
      pend_vld_q  <= pend_vld_d;
      pend_val_q  <= pend_val_d;
      pend_mode_q <= pend_mode_d;
      digit_q     <= digit_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign busy = busy_q;
  assign seg  = seg_q;
  assign an   = an_q;
  assign dp   = 1'b1;

endmodule
`default_nettype wire
